// File: rtl/led_dbg_pkg.sv
// Shared constants and size derivations for the LED debug display unit.
// The slot geometry is computed here so the top and the selector cannot disagree.
package led_dbg_pkg;

    localparam int MODE_SCAN = 0;
    localparam int MODE_SNAP = 1;

    // LED-wide slices per channel word
    function automatic int calc_bpc(input int data_w, input int led_w);
        return data_w / led_w;
    endfunction

    // Every word slice plus one trailing flag slot
    function automatic int calc_nslot(input int data_w, input int nch, input int led_w);
        return nch * calc_bpc(data_w, led_w) + 1;
    endfunction

    function automatic int calc_sel_w(input int nslot);
        return (nslot > 1) ? $clog2(nslot) : 1;
    endfunction

endpackage

// File: rtl/led_slot_sel.sv
// Combinational slot decoder: picks one LED-wide slice of the channel bus,
// or packs the per-channel zero/overflow flags for the final slot.
module led_slot_sel
    import led_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 2,
    parameter int LED_W  = 8,
    parameter int SEL_W  = 4
) (
    input  logic [NCH*DATA_W-1:0] words,
    input  logic [NCH-1:0]        zf,
    input  logic [NCH-1:0]        of,
    input  logic [SEL_W-1:0]      slot,
    output logic [LED_W-1:0]      led_slice
);

    localparam int BPC        = calc_bpc(DATA_W, LED_W);
    localparam int WORD_SLOTS = NCH * BPC;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves led_slice
        // unassigned; otherwise synthesis infers a latch.
        led_slice = '0;
        // Channel words are packed back to back and DATA_W = BPC*LED_W, so
        // slot s (channel s/BPC, slice s%BPC) is simply bus bits s*LED_W upward.
        for (int s = 0; s < WORD_SLOTS; s++) begin
            if (slot == SEL_W'(s)) begin
                led_slice = words[s*LED_W +: LED_W];
            end
        end
        if (slot == SEL_W'(WORD_SLOTS)) begin
            for (int k = 0; k < NCH; k++) begin
                led_slice[2*k]   = zf[k];
                led_slice[2*k+1] = of[k];
            end
        end
    end

endmodule

// File: rtl/led_debug_mux.sv
// Board debug display: live or frozen channel words shown a slice at a time on
// the LED bank, selected by switches or stepped by a timed auto-scan.
module led_debug_mux
    import led_dbg_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NCH      = 2,
    parameter int  LED_W    = 8,
    parameter int  SCAN_DIV = 50_000_000,
    localparam int NSLOT    = calc_nslot(DATA_W, NCH, LED_W),
    localparam int SEL_W    = calc_sel_w(NSLOT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [NCH-1:0]        ch_zf,
    input  logic [NCH-1:0]        ch_of,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    input  logic                  capture,
    output logic [LED_W-1:0]      led,
    output logic [SEL_W-1:0]      cur_slot,
    output logic                  snap_valid
);

    localparam int                PS_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(NSLOT - 1);

    logic [PS_W-1:0]       ps_q, ps_d;
    logic                  prev_scan_q;
    logic [SEL_W-1:0]      slot_d;
    logic [NCH*DATA_W-1:0] snap_data_q, src_data;
    logic [NCH-1:0]        snap_zf_q, snap_of_q, src_zf, src_of;
    logic [LED_W-1:0]      led_d;
    logic                  scan_on;

    assign scan_on = mode[MODE_SCAN];

    always_comb begin
        ps_d   = '0;
        slot_d = cur_slot;
        if (!scan_on) begin
            slot_d = (sel > LAST_SLOT) ? LAST_SLOT : sel;
        end else if (!prev_scan_q) begin
            slot_d = '0;
        end else if (ps_q == PS_LAST) begin
            slot_d = (cur_slot == LAST_SLOT) ? '0 : cur_slot + SEL_W'(1);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // Snapshot registers feed the display before a capture loads them, so the
    // same-cycle capture case naturally shows the previous snapshot.
    assign src_data = mode[MODE_SNAP] ? snap_data_q : ch_data;
    assign src_zf   = mode[MODE_SNAP] ? snap_zf_q   : ch_zf;
    assign src_of   = mode[MODE_SNAP] ? snap_of_q   : ch_of;

    led_slot_sel #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .LED_W  (LED_W),
        .SEL_W  (SEL_W)
    ) u_slot_sel (
        .words     (src_data),
        .zf        (src_zf),
        .of        (src_of),
        .slot      (slot_d),
        .led_slice (led_d)
    );

    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values and evaluation order inside the block cannot matter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_q        <= '0;
            prev_scan_q <= 1'b0;
            cur_slot    <= '0;
            led         <= '0;
            // NOTE: the snapshot bank is deliberately reset, since an empty
            // snapshot must display as zeros rather than power-up garbage.
            snap_data_q <= '0;
            snap_zf_q   <= '0;
            snap_of_q   <= '0;
            snap_valid  <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            prev_scan_q <= scan_on;
            cur_slot    <= slot_d;
            led         <= led_d;
            if (capture) begin
                snap_data_q <= ch_data;
                snap_zf_q   <= ch_zf;
                snap_of_q   <= ch_of;
                snap_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_debug_mux.sv
// Directed plus randomized checks of led_debug_mux against a slot/dwell model
// derived from time spent in scan rather than from a prescaler register.
module tb_led_debug_mux;

    localparam int DATA_W   = 32;
    localparam int NCH      = 2;
    localparam int LED_W    = 8;
    localparam int SCAN_DIV = 4;
    localparam int BPC      = DATA_W / LED_W;
    localparam int NSLOT    = NCH * BPC + 1;
    localparam int SEL_W    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH*DATA_W-1:0] ch_data;
    logic [NCH-1:0]        ch_zf, ch_of;
    logic [SEL_W-1:0]      sel;
    logic [1:0]            mode;
    logic                  capture;
    logic [LED_W-1:0]      led;
    logic [SEL_W-1:0]      cur_slot;
    logic                  snap_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                    m_age;
    bit                    m_in_scan;
    int                    m_slot;
    logic [LED_W-1:0]      m_led;
    logic [NCH*DATA_W-1:0] m_snap_data;
    logic [NCH-1:0]        m_snap_zf, m_snap_of;
    bit                    m_sv;

    led_debug_mux #(
        .DATA_W   (DATA_W),
        .NCH      (NCH),
        .LED_W    (LED_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .ch_zf      (ch_zf),
        .ch_of      (ch_of),
        .sel        (sel),
        .mode       (mode),
        .capture    (capture),
        .led        (led),
        .cur_slot   (cur_slot),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LED_W-1:0] expect_led(input int slot,
                                                   input logic [NCH*DATA_W-1:0] words,
                                                   input logic [NCH-1:0] zf,
                                                   input logic [NCH-1:0] of);
        logic [DATA_W-1:0] w;
        logic [LED_W-1:0]  r;
        r = '0;
        if (slot < NCH * BPC) begin
            w = DATA_W'(words >> ((slot / BPC) * DATA_W));
            r = LED_W'(w >> ((slot % BPC) * LED_W));
        end else begin
            for (int k = 0; k < NCH; k++) begin
                r[2*k]   = zf[k];
                r[2*k+1] = of[k];
            end
        end
        return r;
    endfunction

    // Advance the model from the inputs in force, clock once, compare outputs.
    task automatic tick();
        if (!rst) begin
            m_age = 0; m_in_scan = 0; m_slot = 0; m_led = '0;
            m_snap_data = '0; m_snap_zf = '0; m_snap_of = '0; m_sv = 0;
        end else begin
            if (!mode[0]) begin
                m_slot = (int'(sel) >= NSLOT) ? NSLOT - 1 : int'(sel);
            end else begin
                m_age  = m_in_scan ? m_age + 1 : 0;
                m_slot = (m_age / SCAN_DIV) % NSLOT;
            end
            m_in_scan = mode[0];
            m_led = mode[1] ? expect_led(m_slot, m_snap_data, m_snap_zf, m_snap_of)
                            : expect_led(m_slot, ch_data, ch_zf, ch_of);
            if (capture) begin
                m_snap_data = ch_data; m_snap_zf = ch_zf; m_snap_of = ch_of; m_sv = 1;
            end
        end
        @(posedge clk);
        #1;
        check("led", 32'(led), 32'(m_led));
        check("cur_slot", 32'(cur_slot), 32'(m_slot));
        check("snap_valid", 32'(snap_valid), 32'(m_sv));
    endtask

    initial begin
        int n;
        // Reset with arbitrary inputs, including a capture that must be dropped
        rst = 1'b0;
        ch_data = {$urandom, $urandom}; ch_zf = 2'($urandom); ch_of = 2'($urandom);
        sel = 4'($urandom); mode = 2'($urandom); capture = 1'b1;
        tick();
        tick();
        check("rst_led", 32'(led), 32'h0);
        check("rst_slot", 32'(cur_slot), 32'h0);
        check("rst_sv", 32'(snap_valid), 32'h0);

        rst = 1'b1; ch_data = '0; ch_zf = '0; ch_of = '0; sel = '0; mode = 2'b00; capture = 1'b0;
        tick();
        check("post_rst_led", 32'(led), 32'h0);
        check("post_rst_slot", 32'(cur_slot), 32'h0);

        // Snapshot source before any capture shows zeros
        ch_data = {$urandom | 32'h1, $urandom | 32'h1}; mode = 2'b10; sel = 4'd1;
        tick();
        check("empty_snap_led", 32'(led), 32'h0);
        check("empty_snap_sv", 32'(snap_valid), 32'h0);

        // Direct select
        ch_data = {32'hDEADBEEF, 32'h12345678}; mode = 2'b00;
        ch_zf = 2'b10; ch_of = 2'b01;
        sel = 4'd0;  tick(); check("sel0", 32'(led), 32'h78);
        sel = 4'd3;  tick(); check("sel3", 32'(led), 32'h12);
        sel = 4'd7;  tick(); check("sel7", 32'(led), 32'hDE);
        sel = 4'd8;  tick(); check("sel8_flags", 32'(led), 32'h06);
        sel = 4'd15; tick(); check("sel15_flags", 32'(led), 32'h06);
        check("sel15_slot", 32'(cur_slot), 32'd8);

        // Scan: full lap plus a bit, slot dwell SCAN_DIV
        mode = 2'b01;
        for (int i = 0; i < NSLOT * SCAN_DIV + 6; i++) begin
            tick();
            if (i == SCAN_DIV - 1) check("dwell_end", 32'(cur_slot), 32'd0);
            if (i == SCAN_DIV)     check("first_adv", 32'(cur_slot), 32'd1);
            if (i == NSLOT * SCAN_DIV) check("scan_wrap", 32'(cur_slot), 32'd0);
            if (i % 7 == 3) ch_data = {$urandom, $urandom};
            if (i == 20) mode = 2'b11;
        end

        // Capture / freeze
        mode = 2'b00; sel = 4'd0; ch_data[31:0] = 32'hAAAA5555; capture = 1'b1;
        tick();
        capture = 1'b0; ch_data[31:0] = 32'h0;
        tick();
        mode = 2'b10; sel = 4'd0;
        tick();
        check("frozen_led", 32'(led), 32'h55);
        check("frozen_sv", 32'(snap_valid), 32'h1);
        ch_data[31:0] = 32'h11223344; capture = 1'b1;
        tick();
        check("cap_same_cycle", 32'(led), 32'h55);
        capture = 1'b0;
        tick();
        check("cap_next_cycle", 32'(led), 32'h44);

        // Reset mid-scan together with a capture
        mode = 2'b01;
        n = 0;
        while (m_slot != 5 && n < 100) begin
            tick();
            n++;
        end
        check("reach_slot5", 32'(n < 100), 32'h1);
        check("at_slot5", 32'(cur_slot), 32'd5);
        rst = 1'b0; capture = 1'b1;
        tick();
        check("midscan_rst_slot", 32'(cur_slot), 32'd0);
        check("midscan_rst_sv", 32'(snap_valid), 32'h0);
        rst = 1'b1; capture = 1'b0;
        for (int i = 0; i < SCAN_DIV + 2; i++) tick();
        check("restart_slot", 32'(cur_slot), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            ch_data = {$urandom, $urandom};
            ch_zf   = 2'($urandom);
            ch_of   = 2'($urandom);
            sel     = 4'($urandom);
            capture = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            rst = ($urandom_range(0, 60) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
